sample_dumper: RTL and testbench
================================

Name: sample_dumper

Overview:
- Read-back counterpart of the sample capture block: once a capture finishes, this block sweeps the sample RAM from address 0 to LAST_ADDR.
- It hands each byte, in address order, to the RS232 transmitter through a start/busy handshake.
- It sits between the sample RAM read port and the UART TX, and pulses oFinished when the whole dump has been sent.

Parameters:
- ADDR_WIDTH, 16, width of the sample RAM address.
- DATA_WIDTH, 8, width of a RAM word and of a UART byte.
- LAST_ADDR, 16'hFFFF, final address dumped (inclusive); must be <= 2^ADDR_WIDTH-1.
- RAM_LATENCY, 1, cycles from oAddress change to valid iData (1..3).

Ports:
- iClock, in, 1, single system clock; all logic on posedge.
- iReset, in, 1, asynchronous, active-high reset.
- iStartSignal, in, 1, level/pulse; sampled only in IDLE.
- oAddress, out, ADDR_WIDTH, sample RAM read address.
- iData, in, DATA_WIDTH, RAM read data, valid RAM_LATENCY cycles after oAddress.
- oTxData, out, DATA_WIDTH, byte presented to the UART TX; held stable from the oTxStart pulse until the handshake completes.
- oTxStart, out, 1, one-cycle request pulse to the UART TX.
- iTxBusy, in, 1, high while the UART TX is shifting a byte.
- oBusy, out, 1, high in every state except IDLE.
- oFinished, out, 1, one-cycle pulse after the last byte has been sent.

Behaviour:
- Reset (async, immediate): state=IDLE, oAddress=0, oTxData=0, oTxStart=0, oBusy=0, oFinished=0, latency counter=0. This applies at any point mid-dump; no partial byte is completed.
- FSM states and transitions:
  - IDLE: oAddress held at 0. If iStartSignal=1 -> FETCH.
  - FETCH: load the latency counter with RAM_LATENCY-1 -> WAIT_RAM.
  - WAIT_RAM: decrement the counter each cycle. At 0, register iData into oTxData -> WAIT_IDLE.
  - WAIT_IDLE: while iTxBusy=1, stay. When iTxBusy=0, assert oTxStart for exactly this one cycle -> WAIT_ACK.
  - WAIT_ACK: wait for iTxBusy=1 -> WAIT_TX.
  - WAIT_TX: wait for iTxBusy=0 -> NEXT.
  - NEXT: if oAddress==LAST_ADDR -> DONE. Otherwise oAddress<=oAddress+1 -> FETCH.
  - DONE: oFinished=1 for one cycle; oAddress<=0 -> IDLE.
- Termination uses an equality compare, never `<`. LAST_ADDR=2^ADDR_WIDTH-1 must finish without the address wrapping and without looping forever.
- iStartSignal is ignored outside IDLE; a start held high through DONE begins a new dump 1 cycle after returning to IDLE.
- Total bytes sent: LAST_ADDR+1. oTxStart pulses exactly once per byte.
- Per-byte overhead, excluding UART time: RAM_LATENCY+4 cycles minimum.
- iData is sampled only at the end of WAIT_RAM and ignored at all other times.
- oBusy = (state != IDLE), registered.

Optional Feature:
- Macro: DUMPER_CHECKSUM_EN.
- When defined:
  - An 8-bit accumulator clears on leaving IDLE and adds each sent byte modulo 256.
  - NEXT at LAST_ADDR goes to state CHECKSUM instead of DONE.
  - CHECKSUM loads the accumulator into oTxData and reuses WAIT_IDLE/WAIT_ACK/WAIT_TX with a flag set, then goes to DONE.
  - Total bytes = LAST_ADDR+2.
- When undefined: no accumulator, no CHECKSUM state, behaviour exactly as above.

Decomposition:
- Shared package (dump_pkg): state encoding constants (IDLE, FETCH, WAIT_RAM, WAIT_IDLE, WAIT_ACK, WAIT_TX, NEXT, DONE, CHECKSUM) and the default ADDR_WIDTH/DATA_WIDTH constants, shared with the sample capture block.
- One natural sub-module: tx_handshake. It covers the WAIT_IDLE/WAIT_ACK/WAIT_TX sequencing: input byte plus go, output oTxStart plus done pulse. It is reused by the checksum path.

Test Plan:
- LAST_ADDR=3, RAM holds 8'hA5,8'h01,8'hFF,8'h3C, UART model asserts busy 1 cycle after start and holds it 10 cycles -> exactly 4 oTxStart pulses with oTxData A5,01,FF,3C in order, then one oFinished pulse, oAddress=0, oBusy=0.
- Full range, ADDR_WIDTH=4, LAST_ADDR=15, busy held 2 cycles -> 16 bytes sent, no address wrap, oFinished once; a second start 1 cycle later dumps again from address 0.
- iTxBusy already high when the first byte is ready (held 20 cycles) -> oTxStart stays low until busy falls, then pulses once; iStartSignal pulses mid-dump do not restart or duplicate bytes.
- iReset asserted asynchronously (between clock edges) during WAIT_TX at address 2 -> all outputs return to reset values immediately; next start dumps from address 0.
- RAM_LATENCY=3 with RAM output changing every cycle -> each byte captured is the word for the current oAddress, sampled exactly 3 cycles after the address change.
- DUMPER_CHECKSUM_EN defined, bytes 8'hF0,8'h20,8'h05 (LAST_ADDR=2) -> 4 bytes sent, last = 8'h15, then oFinished.

Source files
------------

// File: rtl/sample_dumper_pkg.sv
// dump_pkg: definitions shared by the sample dumper and the sample capture block.
//   dump_state_t    - dumper FSM state encoding; the TX handshake reuses the
//                     IDLE/WAIT_IDLE/WAIT_ACK/WAIT_TX members
//   DUMP_ADDR_WIDTH - default sample RAM address width
//   DUMP_DATA_WIDTH - default sample RAM word / UART byte width
package dump_pkg;

  localparam int DUMP_ADDR_WIDTH = 16;
  localparam int DUMP_DATA_WIDTH = 8;

  typedef enum logic [3:0] {
    IDLE,
    FETCH,
    WAIT_RAM,
    WAIT_IDLE,
    WAIT_ACK,
    WAIT_TX,
    NEXT,
    DONE,
    CHECKSUM
  } dump_state_t;

endpackage

// File: rtl/sample_dumper_tx_handshake.sv
// tx_handshake: start/busy handshake with the RS232 transmitter for one byte.
// The byte itself is held by the caller; this block only sequences it.
//   clk   - system clock
//   rst   - asynchronous active-high reset
//   go    - one-cycle request to send the byte currently held by the caller
//   busy  - UART TX busy
//   start - registered one-cycle start pulse to the UART TX
//   done  - registered one-cycle pulse once the UART has finished the byte
module tx_handshake
  import dump_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic go,
  input  logic busy,
  output logic start,
  output logic done
);

  dump_state_t state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      start <= 1'b0;
      done  <= 1'b0;
    end else begin
      start <= 1'b0;
      done  <= 1'b0;
      unique case (state)
        // A free UART on request skips the WAIT_IDLE cycle entirely.
        IDLE: begin
          if (go) begin
            if (!busy) begin
              start <= 1'b1;
              state <= WAIT_ACK;
            end else begin
              state <= WAIT_IDLE;
            end
          end
        end
        WAIT_IDLE: begin
          if (!busy) begin
            start <= 1'b1;
            state <= WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          if (busy) state <= WAIT_TX;
        end
        WAIT_TX: begin
          if (!busy) begin
            done  <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/sample_dumper.sv
// sample_dumper: after a capture, reads sample RAM addresses 0..LAST_ADDR in
// order and sends each word through the UART TX handshake.
//   iClock       - system clock
//   iReset       - asynchronous active-high reset
//   iStartSignal - start a dump (sampled only while idle)
//   oAddress     - sample RAM read address
//   iData        - RAM read data, valid RAM_LATENCY cycles after oAddress
//   oTxData      - byte presented to the UART TX
//   oTxStart     - one-cycle start pulse to the UART TX
//   iTxBusy      - UART TX busy
//   oBusy        - high whenever the dumper is not idle
//   oFinished    - one-cycle pulse after the final byte
// Optional build macro DUMPER_CHECKSUM_EN appends a modulo-256 sum of all
// dumped bytes as one extra trailing byte.
module sample_dumper
  import dump_pkg::*;
#(
  parameter int          ADDR_WIDTH  = DUMP_ADDR_WIDTH,
  parameter int          DATA_WIDTH  = DUMP_DATA_WIDTH,
  parameter int unsigned LAST_ADDR   = 16'hFFFF,
  parameter int          RAM_LATENCY = 1
) (
  input  logic                  iClock,
  input  logic                  iReset,
  input  logic                  iStartSignal,
  output logic [ADDR_WIDTH-1:0] oAddress,
  input  logic [DATA_WIDTH-1:0] iData,
  output logic [DATA_WIDTH-1:0] oTxData,
  output logic                  oTxStart,
  input  logic                  iTxBusy,
  output logic                  oBusy,
  output logic                  oFinished
);

  localparam logic [ADDR_WIDTH-1:0] END_ADDR = ADDR_WIDTH'(LAST_ADDR);
  localparam logic [1:0]            LAT_LOAD = 2'(RAM_LATENCY - 1);

  dump_state_t state;
  logic [1:0]  lat_cnt;
  logic        hs_go;
  logic        hs_done;

`ifdef DUMPER_CHECKSUM_EN
  logic [7:0] csum;
  logic       csum_phase;
`endif

  tx_handshake u_tx_handshake (
    .clk   (iClock),
    .rst   (iReset),
    .go    (hs_go),
    .busy  (iTxBusy),
    .start (oTxStart),
    .done  (hs_done)
  );

  // While the handshake runs, this FSM parks in WAIT_TX; the handshake block
  // walks WAIT_IDLE/WAIT_ACK/WAIT_TX itself and reports back with hs_done.
  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      state     <= IDLE;
      oAddress  <= '0;
      oTxData   <= '0;
      oBusy     <= 1'b0;
      oFinished <= 1'b0;
      lat_cnt   <= '0;
      hs_go     <= 1'b0;
`ifdef DUMPER_CHECKSUM_EN
      csum       <= '0;
      csum_phase <= 1'b0;
`endif
    end else begin
      hs_go     <= 1'b0;
      oFinished <= 1'b0;
      unique case (state)
        IDLE: begin
          oAddress <= '0;
          if (iStartSignal) begin
            oBusy <= 1'b1;
            state <= FETCH;
`ifdef DUMPER_CHECKSUM_EN
            csum       <= '0;
            csum_phase <= 1'b0;
`endif
          end
        end
        FETCH: begin
          lat_cnt <= LAT_LOAD;
          state   <= WAIT_RAM;
        end
        WAIT_RAM: begin
          if (lat_cnt == '0) begin
            oTxData <= iData;
            hs_go   <= 1'b1;
            state   <= WAIT_TX;
          end else begin
            lat_cnt <= lat_cnt - 2'd1;
          end
        end
        WAIT_TX: begin
          if (hs_done) begin
`ifdef DUMPER_CHECKSUM_EN
            if (csum_phase) begin
              state <= DONE;
            end else begin
              csum  <= csum + 8'(oTxData);
              state <= NEXT;
            end
`else
            state <= NEXT;
`endif
          end
        end
        // Equality test so a full-range LAST_ADDR ends before the address wraps.
        NEXT: begin
          if (oAddress == END_ADDR) begin
`ifdef DUMPER_CHECKSUM_EN
            state <= CHECKSUM;
`else
            state <= DONE;
`endif
          end else begin
            oAddress <= oAddress + 1'b1;
            state    <= FETCH;
          end
        end
`ifdef DUMPER_CHECKSUM_EN
        CHECKSUM: begin
          oTxData    <= DATA_WIDTH'(csum);
          csum_phase <= 1'b1;
          hs_go      <= 1'b1;
          state      <= WAIT_TX;
        end
`endif
        DONE: begin
          oFinished <= 1'b1;
          oAddress  <= '0;
          oBusy     <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sample_dumper.sv
// Directed bench for sample_dumper with two instances:
//   A: LAST_ADDR=3, RAM_LATENCY=1, 16-bit address (short dump, busy stall,
//      mid-dump start pulses, asynchronous reset)
//   B: ADDR_WIDTH=4, LAST_ADDR=15, RAM_LATENCY=3 (full range, back-to-back dump,
//      delayed RAM read)
// Honours DUMPER_CHECKSUM_EN by expecting the trailing checksum byte.
module tb_sample_dumper;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  // ---------------- instance A ----------------
  logic        start_a;
  logic [15:0] addr_a;
  logic [7:0]  data_a, txd_a;
  logic        txs_a, txb_a, busy_a, fin_a;
  logic [7:0]  mem_a [4];
  int unsigned hold_a = 10;
  int unsigned ucnt_a = 0;
  logic        force_a;

  assign txb_a = (ucnt_a != 0) || force_a;

  always @(posedge clk) begin
    data_a <= mem_a[addr_a[1:0]];
    if (txs_a) ucnt_a <= hold_a;
    else if (ucnt_a != 0) ucnt_a <= ucnt_a - 1;
  end

  sample_dumper #(.ADDR_WIDTH(16), .DATA_WIDTH(8), .LAST_ADDR(3), .RAM_LATENCY(1)) u_dut_a (
    .iClock(clk), .iReset(rst), .iStartSignal(start_a), .oAddress(addr_a), .iData(data_a),
    .oTxData(txd_a), .oTxStart(txs_a), .iTxBusy(txb_a), .oBusy(busy_a), .oFinished(fin_a)
  );

  // ---------------- instance B ----------------
  logic        start_b;
  logic [3:0]  addr_b;
  logic [7:0]  p1_b, p2_b, data_b, txd_b;
  logic        txs_b, txb_b, busy_b, fin_b;
  logic [7:0]  mem_b [16];
  int unsigned hold_b = 2;
  int unsigned ucnt_b = 0;

  assign txb_b = (ucnt_b != 0);

  // Three-stage read pipeline: a word sampled too early belongs to the old address.
  always @(posedge clk) begin
    p1_b   <= mem_b[addr_b];
    p2_b   <= p1_b;
    data_b <= p2_b;
    if (txs_b) ucnt_b <= hold_b;
    else if (ucnt_b != 0) ucnt_b <= ucnt_b - 1;
  end

  sample_dumper #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .LAST_ADDR(15), .RAM_LATENCY(3)) u_dut_b (
    .iClock(clk), .iReset(rst), .iStartSignal(start_b), .oAddress(addr_b), .iData(data_b),
    .oTxData(txd_b), .oTxStart(txs_b), .iTxBusy(txb_b), .oBusy(busy_b), .oFinished(fin_b)
  );

  // ---------------- monitors ----------------
  logic [7:0] got_a[$];
  logic [7:0] got_b[$];
  int         fin_cnt_a = 0;
  int         fin_cnt_b = 0;

  always @(negedge clk) begin
    if (txs_a) got_a.push_back(txd_a);
    if (txs_b) got_b.push_back(txd_b);
    if (fin_a) fin_cnt_a++;
    if (fin_b) fin_cnt_b++;
  end

  // ---------------- expectations ----------------
`ifdef DUMPER_CHECKSUM_EN
  localparam int N_A = 5;
  localparam int N_B = 17;
`else
  localparam int N_A = 4;
  localparam int N_B = 16;
`endif
  // A5+01+FF+3C = 0x1E1 -> E1 modulo 256
  logic [7:0] exp_a [5] = '{8'hA5, 8'h01, 8'hFF, 8'h3C, 8'hE1};
  logic [7:0] exp_b [17];

  task automatic check_dump_a(input string tag, input int base);
    logic [7:0] v;
    chk($sformatf("%s_count", tag), 32'(got_a.size() - base), 32'(N_A));
    for (int i = 0; i < N_A; i++) begin
      v = (base + i < got_a.size()) ? got_a[base + i] : 8'hxx;
      chk($sformatf("%s_byte%0d", tag, i), 32'(v), 32'(exp_a[i]));
    end
  endtask

  task automatic check_dump_b(input string tag, input int base);
    logic [7:0] v;
    chk($sformatf("%s_count", tag), 32'(got_b.size() - base), 32'(N_B));
    for (int i = 0; i < N_B; i++) begin
      v = (base + i < got_b.size()) ? got_b[base + i] : 8'hxx;
      chk($sformatf("%s_byte%0d", tag, i), 32'(v), 32'(exp_b[i]));
    end
  endtask

  task automatic wait_fin(input bit which_b, input int base, input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if ((which_b ? fin_cnt_b : fin_cnt_a) != base) begin
        seen = 1'b1;
        break;
      end
    end
    chk(which_b ? "finish_b_seen" : "finish_a_seen", 32'(seen), 32'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int  base_q, base_f;
    bit  hit;
    logic [7:0] sum;

    rst = 1'b1; start_a = 1'b0; start_b = 1'b0; force_a = 1'b0;
    mem_a[0] = 8'hA5; mem_a[1] = 8'h01; mem_a[2] = 8'hFF; mem_a[3] = 8'h3C;
    sum = 8'h00;
    for (int i = 0; i < 16; i++) begin
      mem_b[i] = 8'(i * 37 + 11);
      exp_b[i] = mem_b[i];
      sum      = sum + mem_b[i];
    end
    exp_b[16] = sum;

    repeat (3) @(negedge clk);
    chk("rst_addr_a", 32'(addr_a), 0);
    chk("rst_txdata_a", 32'(txd_a), 0);
    chk("rst_txstart_a", 32'(txs_a), 0);
    chk("rst_busy_a", 32'(busy_a), 0);
    chk("rst_fin_a", 32'(fin_a), 0);
    chk("rst_addr_b", 32'(addr_b), 0);
    chk("rst_busy_b", 32'(busy_b), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Short dump, busy held 10 cycles
    base_q = got_a.size(); base_f = fin_cnt_a;
    start_a = 1'b1; @(negedge clk); start_a = 1'b0;
    chk("busy_a_running", 32'(busy_a), 1);
    wait_fin(1'b0, base_f, 2000);
    chk("t1_addr_after", 32'(addr_a), 0);
    chk("t1_busy_after", 32'(busy_a), 0);
    repeat (3) @(negedge clk);
    chk("t1_fin_once", 32'(fin_cnt_a - base_f), 1);
    check_dump_a("t1", base_q);

    // Full range on B, then an immediate second dump
    base_q = got_b.size(); base_f = fin_cnt_b;
    start_b = 1'b1; @(negedge clk); start_b = 1'b0;
    wait_fin(1'b1, base_f, 3000);
    chk("t2_addr_after", 32'(addr_b), 0);
    chk("t2_busy_after", 32'(busy_b), 0);
    start_b = 1'b1; @(negedge clk); start_b = 1'b0;
    chk("t2_restart_busy", 32'(busy_b), 1);
    check_dump_b("t2a", base_q);
    chk("t2_fin_once", 32'(fin_cnt_b - base_f), 1);
    base_q = base_q + N_B; base_f = fin_cnt_b;
    wait_fin(1'b1, base_f, 3000);
    repeat (3) @(negedge clk);
    check_dump_b("t2b", base_q);
    chk("t2b_fin_once", 32'(fin_cnt_b - base_f), 1);

    // UART busy when the first byte is ready; start pulses mid-dump
    base_q = got_a.size(); base_f = fin_cnt_a;
    force_a = 1'b1;
    start_a = 1'b1; @(negedge clk); start_a = 1'b0;
    repeat (19) @(negedge clk);
    chk("t3_no_start_while_busy", 32'(got_a.size() - base_q), 0);
    chk("t3_busy_stalled", 32'(busy_a), 1);
    force_a = 1'b0;
    repeat (3) begin
      repeat (7) @(negedge clk);
      start_a = 1'b1; @(negedge clk); start_a = 1'b0;
    end
    wait_fin(1'b0, base_f, 2000);
    repeat (3) @(negedge clk);
    chk("t3_fin_once", 32'(fin_cnt_a - base_f), 1);
    check_dump_a("t3", base_q);

    // Asynchronous reset while the UART is sending address 2
    start_a = 1'b1; @(negedge clk); start_a = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (addr_a == 16'd2 && txb_a) begin
        hit = 1'b1;
        break;
      end
    end
    chk("t4_reached_addr2", 32'(hit), 1);
    @(posedge clk); #2;
    chk("t4_txdata_before_rst", 32'(txd_a), 32'hFF);
    rst = 1'b1; #1;
    chk("t4_rst_addr", 32'(addr_a), 0);
    chk("t4_rst_txdata", 32'(txd_a), 0);
    chk("t4_rst_txstart", 32'(txs_a), 0);
    chk("t4_rst_busy", 32'(busy_a), 0);
    chk("t4_rst_fin", 32'(fin_a), 0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    base_q = got_a.size(); base_f = fin_cnt_a;
    start_a = 1'b1; @(negedge clk); start_a = 1'b0;
    wait_fin(1'b0, base_f, 2000);
    repeat (3) @(negedge clk);
    check_dump_a("t4", base_q);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
